// File: rtl/bsg_fpu_classify_pipe.sv
// Two-stage pipelined IEEE-754 classifier producing the RISC-V FCLASS one-hot
// result, with saturating per-class retirement counters for profiling.
module bsg_fpu_classify_pipe #(
  parameter int unsigned e_p           = 8,
  parameter int unsigned m_p           = 23,
  parameter int unsigned width_p       = 1 + e_p + m_p,
  parameter int unsigned count_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [width_p-1:0]            a_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            class_o,
  input  logic                          yumi_i,
  input  logic                          clear_i,
  output logic [10*count_width_p-1:0]   counts_o
);

  localparam int unsigned num_class_lp = 10;

  logic                     s0_v_q, s0_v_d;
  logic [width_p-1:0]       s0_a_q, s0_a_d;
  logic                     v_q, v_d;
  logic [num_class_lp-1:0]  class_q, class_d, class_dec;
  logic [count_width_p-1:0] cnt_q [num_class_lp];
  logic [count_width_p-1:0] cnt_d [num_class_lp];

  logic s1_adv, accept, retire;
  logic sign, exp_zero, exp_ones, man_zero, man_msb;

  assign s1_adv  = ~v_q | yumi_i;
  assign ready_o = ~s0_v_q | s1_adv;
  assign accept  = v_i & ready_o;
  assign retire  = v_q & yumi_i;

  assign sign     = s0_a_q[width_p-1];
  assign exp_zero = ~|s0_a_q[m_p +: e_p];
  assign exp_ones = &s0_a_q[m_p +: e_p];
  assign man_zero = ~|s0_a_q[m_p-1:0];
  assign man_msb  = s0_a_q[m_p-1];

  // Class decode of the stage-0 operand; NaN classes ignore the sign
  always_comb begin
    class_dec = '0;
    if (exp_ones) begin
      if (!man_zero) begin
        if (man_msb) class_dec[9] = 1'b1;
        else         class_dec[8] = 1'b1;
      end else if (sign) begin
        class_dec[0] = 1'b1;
      end else begin
        class_dec[7] = 1'b1;
      end
    end else if (exp_zero) begin
      if (man_zero) begin
        if (sign) class_dec[3] = 1'b1;
        else      class_dec[4] = 1'b1;
      end else if (sign) begin
        class_dec[2] = 1'b1;
      end else begin
        class_dec[5] = 1'b1;
      end
    end else if (sign) begin
      class_dec[1] = 1'b1;
    end else begin
      class_dec[6] = 1'b1;
    end
  end

  always_comb begin
    s0_v_d  = s0_v_q;
    s0_a_d  = s0_a_q;
    v_d     = v_q;
    class_d = class_q;
    if (s1_adv) begin
      v_d = s0_v_q;
      if (s0_v_q) class_d = class_dec;
    end
    if (accept) begin
      s0_v_d = 1'b1;
      s0_a_d = a_i;
    end else if (s0_v_q && s1_adv) begin
      s0_v_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle retirement; counters stick at all-ones
  always_comb begin
    for (int k = 0; k < num_class_lp; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (retire && class_q[k] && !(&cnt_q[k])) begin
        cnt_d[k] = cnt_q[k] + count_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s0_v_q  <= 1'b0;
      s0_a_q  <= '0;
      v_q     <= 1'b0;
      class_q <= '0;
      for (int k = 0; k < num_class_lp; k++) cnt_q[k] <= '0;
    end else begin
      s0_v_q  <= s0_v_d;
      s0_a_q  <= s0_a_d;
      v_q     <= v_d;
      class_q <= class_d;
      for (int k = 0; k < num_class_lp; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign v_o     = v_q;
  assign class_o = width_p'(class_q);

  for (genvar k = 0; k < num_class_lp; k++) begin : g_counts
    assign counts_o[k*count_width_p +: count_width_p] = cnt_q[k];
  end

endmodule

// File: tb/tb_bsg_fpu_classify_pipe.sv
// Scoreboard bench: single-precision DUT (16-bit counters) and half-precision
// DUT (2-bit counters) sharing the clock and reset.
module tb_bsg_fpu_classify_pipe;

  localparam int unsigned CW  = 16;
  localparam int unsigned HCW = 2;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic              v_i, ready_o, v_o, yumi_i, clear_i;
  logic [31:0]       a_i, class_o;
  logic [10*CW-1:0]  counts_o;

  logic              vh_i, readyh_o, vh_o, yumih_i, clearh_i;
  logic [15:0]       ah_i, classh_o;
  logic [10*HCW-1:0] countsh_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] q[$];
  logic [9:0] qh[$];
  int exp_cnt[10];

  bsg_fpu_classify_pipe #(.count_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i), .ready_o(ready_o),
    .v_o(v_o), .class_o(class_o), .yumi_i(yumi_i), .clear_i(clear_i),
    .counts_o(counts_o)
  );

  bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .count_width_p(HCW)) dut_h (
    .clk_i(clk), .reset_i(reset_i), .v_i(vh_i), .a_i(ah_i), .ready_o(readyh_o),
    .v_o(vh_o), .class_o(classh_o), .yumi_i(yumih_i), .clear_i(clearh_i),
    .counts_o(countsh_o)
  );

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [9:0] ref_class(input logic [31:0] a);
    logic s;
    logic [7:0] ex;
    logic [22:0] mn;
    s = a[31]; ex = a[30:23]; mn = a[22:0];
    if (ex == 8'hFF) begin
      if (mn != 23'd0) return mn[22] ? 10'h200 : 10'h100;
      return s ? 10'h001 : 10'h080;
    end
    if (ex == 8'h00) begin
      if (mn == 23'd0) return s ? 10'h008 : 10'h010;
      return s ? 10'h004 : 10'h020;
    end
    return s ? 10'h002 : 10'h040;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      3: r[30:0] = 31'd0;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [159:0] pack_cnt(input int c[10]);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'(c[k]);
    return r;
  endfunction

  // Monitors: pop the oldest expectation whenever a result retires
  always @(negedge clk) begin : mon_s
    logic [9:0] e;
    if (!reset_i && v_o === 1'b1 && yumi_i === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %0h expected none", class_o);
      end else begin
        e = q.pop_front();
        check("class", 160'(class_o), 160'(e));
        check("onehot", 160'($onehot(class_o)), 160'd1);
        for (int k = 0; k < 10; k++) if (e[k]) exp_cnt[k]++;
      end
    end
  end

  always @(negedge clk) begin : mon_h
    logic [9:0] e;
    if (!reset_i && vh_o === 1'b1 && yumih_i === 1'b1) begin
      if (qh.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_half_result: got %0h expected none", classh_o);
      end else begin
        e = qh.pop_front();
        check("half_class", 160'(classh_o), 160'(e));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [9:0] e);
    v_i = 1'b1; a_i = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        q.push_back(e);
        @(posedge clk); #1;
        v_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL send_timeout: got ready_o=0 expected 1 within 60 cycles");
    v_i = 1'b0;
  endtask

  task automatic sendh(input logic [15:0] a, input logic [9:0] e);
    vh_i = 1'b1; ah_i = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (readyh_o) begin
        qh.push_back(e);
        @(posedge clk); #1;
        vh_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL sendh_timeout: got ready_o=0 expected 1 within 60 cycles");
    vh_i = 1'b0;
  endtask

  task automatic drain();
    v_i = 1'b0; yumi_i = 1'b1;
    for (int i = 0; i < 60 && (q.size() != 0 || v_o); i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic drainh();
    vh_i = 1'b0; yumih_i = 1'b1;
    for (int i = 0; i < 60 && (qh.size() != 0 || vh_o); i++) begin
      @(posedge clk); #1;
    end
    if (qh.size() != 0) begin
      n_checks++;
      $display("FAIL drainh_timeout: got %0d pending expected 0", qh.size());
      qh.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int hc[10];
    logic pend;
    reset_i = 1'b1;
    v_i = 0; a_i = '0; yumi_i = 0; clear_i = 0;
    vh_i = 0; ah_i = '0; yumih_i = 0; clearh_i = 0;
    for (int k = 0; k < 10; k++) exp_cnt[k] = 0;
    #1;
    check("rst_v_o", 160'(v_o), 160'd0);
    check("rst_class_o", 160'(class_o), 160'd0);
    check("rst_counts", 160'(counts_o), 160'd0);
    check("rst_ready", 160'(ready_o), 160'd1);
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #1;

    // Single precision, one op per cycle with yumi held high
    yumi_i = 1'b1;
    send(32'hFF800000, 10'h001);
    send(32'h7FC00000, 10'h200);
    send(32'h7F800001, 10'h100);
    send(32'h00000001, 10'h020);
    send(32'h80000000, 10'h008);
    send(32'h3F800000, 10'h040);
    drain();
    hc = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
    check("sp_counters", counts_o, pack_cnt(hc));

    // Half precision classes, then 2-bit counter saturation and clear
    yumih_i = 1'b1;
    sendh(16'hFC00, 10'h001);
    sendh(16'h7E00, 10'h200);
    sendh(16'hFE00, 10'h200);
    sendh(16'h0200, 10'h020);
    sendh(16'h8001, 10'h004);
    drainh();
    check("hp_counters", 160'(countsh_o), 160'h00411 | 160'h80000);
    for (int i = 0; i < 5; i++) sendh(16'h0000, 10'h010);
    drainh();
    check("hp_sat_counters", 160'(countsh_o), 160'h80711);
    sendh(16'h3C00, 10'h040);
    @(posedge clk); #1;
    check("hp_clear_v", 160'(vh_o), 160'd1);
    clearh_i = 1'b1;
    @(posedge clk); #1;
    clearh_i = 1'b0;
    check("hp_clear_counters", 160'(countsh_o), 160'd0);

    // Backpressure: yumi low for 5 cycles while streaming 4 ops
    yumi_i = 1'b0;
    fork
      begin
        send(32'h3F800000, 10'h040);
        send(32'hBF800000, 10'h002);
        send(32'h7F800000, 10'h080);
        send(32'h00400000, 10'h020);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check("bp_ready_high", 160'(ready_o), 160'd1);
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_ready_low", 160'(ready_o), 160'd0);
          check("bp_v_hold", 160'(v_o), 160'd1);
          check("bp_class_hold", 160'(class_o), 160'h040);
        end
        @(posedge clk); #1;
        yumi_i = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two ops in flight
    yumi_i = 1'b0;
    send(32'h3F800000, 10'h040);
    send(32'h40000000, 10'h040);
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst_v_o", 160'(v_o), 160'd0);
    check("mid_rst_counts", counts_o, 160'd0);
    check("mid_rst_ready", 160'(ready_o), 160'd1);
    q.delete();
    for (int k = 0; k < 10; k++) exp_cnt[k] = 0;
    #2;
    reset_i = 1'b0;
    @(posedge clk); #1;
    yumi_i = 1'b1;
    send(32'hC0000000, 10'h002);
    check("lat_t1_v_o", 160'(v_o), 160'd0);
    @(posedge clk); #1;
    check("lat_t2_v_o", 160'(v_o), 160'd1);
    drain();

    // Random ops with random valid/yumi against the reference model
    pend = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!pend) begin
        v_i = 1'($urandom_range(0, 1));
        a_i = rand_op();
      end
      yumi_i = v_o & 1'($urandom_range(0, 1));
      @(negedge clk);
      if (v_i && ready_o) begin
        q.push_back(ref_class(a_i));
        pend = 1'b0;
      end else begin
        pend = v_i;
      end
      @(posedge clk); #1;
    end
    drain();
    for (int k = 0; k < 10; k++)
      check($sformatf("rand_cnt%0d", k), 160'(counts_o[k*CW +: CW]), 160'(exp_cnt[k]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
